// File: rtl/pid_pwm_actuator.sv
// PWM actuator for the PID loop: clamps signed duty commands, applies them at period
// boundaries, and drives complementary half-bridge gates with dead-time insertion.
module pid_pwm_actuator #(
  parameter int CMD_W    = 16,
  parameter int CNT_W    = 12,
  parameter int PERIOD   = 1000,
  parameter int DEADTIME = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CMD_W-1:0] cmd,
  output logic        [CNT_W-1:0] duty_active,
  output logic                    sat_hi,
  output logic                    sat_lo,
  output logic                    period_tick,
  output logic                    pwm_hi,
  output logic                    pwm_lo
);

  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic        [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic        [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic signed [CMD_W:0]   PERIOD_S = (CMD_W+1)'(PERIOD);
  localparam logic        [DT_W-1:0]  DT_LAST  = DT_W'(DEADTIME - 1);

  typedef enum logic [2:0] {OFF, DEAD_LO, LO_ON, DEAD_HI, HI_ON} gate_state_t;

  gate_state_t             state, state_next;
  logic        [DT_W-1:0]  dt, dt_next;
  logic        [CNT_W-1:0] cnt, cnt_next, pending, clamped;
  logic                    pending_full, wrap, accept, raw, cmd_neg, cmd_over;
  logic signed [CMD_W:0]   cmd_ext;

  assign wrap      = (cnt == CNT_LAST);
  assign cnt_next  = wrap ? '0 : cnt + 1'b1;
  assign cmd_ready = !pending_full;
  assign accept    = cmd_valid && cmd_ready;
  assign raw       = (cnt < duty_active);
  assign pwm_hi    = (state == HI_ON);
  assign pwm_lo    = (state == LO_ON);

  // Sign-extend one bit so the PERIOD comparison can never wrap.
  assign cmd_ext  = {cmd[CMD_W-1], cmd};
  assign cmd_neg  = cmd_ext[CMD_W];
  assign cmd_over = (cmd_ext > PERIOD_S);

  always_comb begin
    clamped = cmd[CNT_W-1:0];
    if (cmd_neg)       clamped = '0;
    else if (cmd_over) clamped = PERIOD_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      period_tick <= (cnt_next == CNT_LAST);
    end
  end

  // An accept on the wrap cycle skips the buffer so it lands at this very boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active  <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      sat_hi       <= 1'b0;
      sat_lo       <= 1'b0;
    end else begin
      if (accept) begin
        sat_hi <= cmd_over;
        sat_lo <= cmd_neg;
      end
      if (wrap) begin
        if (accept) begin
          duty_active <= clamped;
        end else if (pending_full) begin
          duty_active  <= pending;
          pending_full <= 1'b0;
        end
      end else if (accept) begin
        pending      <= clamped;
        pending_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      dt    <= '0;
    end else begin
      state <= state_next;
      dt    <= dt_next;
    end
  end

  // Every gate turn-on passes through a dead state that must see raw stable for DEADTIME cycles.
  always_comb begin
    state_next = state;
    dt_next    = dt;
    if (!en) begin
      state_next = OFF;
      dt_next    = '0;
    end else begin
      case (state)
        OFF: begin
          state_next = DEAD_LO;
          dt_next    = '0;
        end
        DEAD_LO: begin
          if (raw) begin
            state_next = DEAD_HI;
            dt_next    = '0;
          end else if (dt == DT_LAST) begin
            state_next = LO_ON;
          end else begin
            dt_next = dt + 1'b1;
          end
        end
        LO_ON: begin
          if (raw) begin
            state_next = DEAD_HI;
            dt_next    = '0;
          end
        end
        DEAD_HI: begin
          if (!raw) begin
            state_next = DEAD_LO;
            dt_next    = '0;
          end else if (dt == DT_LAST) begin
            state_next = HI_ON;
          end else begin
            dt_next = dt + 1'b1;
          end
        end
        HI_ON: begin
          if (!raw) begin
            state_next = DEAD_LO;
            dt_next    = '0;
          end
        end
        default: begin
          state_next = OFF;
          dt_next    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_pwm_actuator.sv
// Bench for pid_pwm_actuator: clamp table, hand sequences for boundary timing, and
// random traffic checked each cycle against a history-based model of gate behaviour.
module tb_pid_pwm_actuator;

  localparam int CMD_W    = 16;
  localparam int CNT_W    = 12;
  localparam int PERIOD   = 10;
  localparam int DEADTIME = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic                    cmd_valid = 1'b0;
  logic signed [CMD_W-1:0] cmd = '0;
  logic                    cmd_ready;
  logic        [CNT_W-1:0] duty_active;
  logic                    sat_hi, sat_lo, period_tick, pwm_hi, pwm_lo;

  pid_pwm_actuator #(
    .CMD_W(CMD_W), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEADTIME(DEADTIME)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .duty_active(duty_active), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .period_tick(period_tick), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: duty schedule as plain arithmetic, gates from the sampled en/raw history.
  int m_cnt, m_duty, m_pend;
  bit m_pend_full, m_sat_hi, m_sat_lo, m_acc;
  bit en_h[$];
  bit raw_h[$];

  typedef struct {
    int cmd;
    int exp_duty;
    bit exp_sat_hi;
    bit exp_sat_lo;
  } vec_t;

  vec_t vecs[10];

  function automatic int clampCmd(input int c);
    if (c < 0) return 0;
    if (c > PERIOD) return PERIOD;
    return c;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_cnt = 0; m_duty = 0; m_pend = 0;
    m_pend_full = 0; m_sat_hi = 0; m_sat_lo = 0; m_acc = 0;
    en_h.delete();
    raw_h.delete();
    for (int k = 0; k < DEADTIME + 2; k++) begin
      en_h.push_back(1'b0);
      raw_h.push_back(1'b0);
    end
  endtask

  // A gate is on only if en held and raw stayed on its side across the whole dead window.
  task automatic checkAll();
    int n;
    bit all_en, hi_run, lo_run, exp_hi, exp_lo;
    n = en_h.size();
    all_en = 1; hi_run = 1; lo_run = 1;
    for (int k = n - DEADTIME - 1; k < n; k++) begin
      all_en &= en_h[k];
      hi_run &= raw_h[k];
      if (k >= n - DEADTIME) lo_run &= !raw_h[k];
    end
    exp_hi = en_h[n-DEADTIME-2] && all_en && hi_run;
    exp_lo = all_en && lo_run && (!en_h[n-DEADTIME-2] || !raw_h[n-DEADTIME-1]);
    checkOutput("duty_active", duty_active, m_duty);
    checkOutput("cmd_ready", cmd_ready, !m_pend_full);
    checkOutput("sat_hi", sat_hi, m_sat_hi);
    checkOutput("sat_lo", sat_lo, m_sat_lo);
    checkOutput("period_tick", period_tick, m_cnt == PERIOD - 1);
    checkOutput("pwm_hi", pwm_hi, exp_hi);
    checkOutput("pwm_lo", pwm_lo, exp_lo);
    checkOutput("gates_exclusive", pwm_hi && pwm_lo, 0);
  endtask

  task automatic stepCycle();
    int c;
    en_h.push_back(en);
    raw_h.push_back(m_cnt < m_duty);
    void'(en_h.pop_front());
    void'(raw_h.pop_front());
    m_acc = cmd_valid && !m_pend_full;
    c = int'(cmd);
    if (m_acc) begin
      m_sat_hi = (c > PERIOD);
      m_sat_lo = (c < 0);
    end
    if (m_cnt == PERIOD - 1) begin
      if (m_acc) m_duty = clampCmd(c);
      else if (m_pend_full) begin
        m_duty = m_pend;
        m_pend_full = 0;
      end
      m_cnt = 0;
    end else begin
      if (m_acc) begin
        m_pend = clampCmd(c);
        m_pend_full = 1;
      end
      m_cnt++;
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input bit e, input bit v, input int c);
    en = e;
    cmd_valid = v;
    cmd = CMD_W'(c);
    stepCycle();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 0);
  endtask

  task automatic waitCnt(input int target);
    for (int i = 0; i < PERIOD + 1 && m_cnt != target; i++) applyStimulus(1'b1, 1'b0, 0);
  endtask

  task automatic sendCmd(input int c);
    for (int i = 0; i < 2 * PERIOD && m_pend_full; i++) idle(1);
    if (m_pend_full) checkOutput("ready_wait", cmd_ready, 1);
    applyStimulus(1'b1, 1'b1, c);
  endtask

  task automatic countGates(input int n, output int hi_c, output int lo_c, output int tick_c);
    hi_c = 0; lo_c = 0; tick_c = 0;
    repeat (n) begin
      idle(1);
      hi_c += pwm_hi;
      lo_c += pwm_lo;
      tick_c += period_tick;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    en = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checkOutput("rst_duty", duty_active, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_sat_hi", sat_hi, 0);
    checkOutput("rst_sat_lo", sat_lo, 0);
    checkOutput("rst_tick", period_tick, 0);
    checkOutput("rst_pwm_hi", pwm_hi, 0);
    checkOutput("rst_pwm_lo", pwm_lo, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAll();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi_c, lo_c, tick_c, c;
    bit e, v;
    logic signed [15:0] r16;

    vecs[0] = '{-5, 0, 1'b0, 1'b1};
    vecs[1] = '{0, 0, 1'b0, 1'b0};
    vecs[2] = '{4, 4, 1'b0, 1'b0};
    vecs[3] = '{10, 10, 1'b0, 1'b0};
    vecs[4] = '{11, 10, 1'b1, 1'b0};
    vecs[5] = '{300, 10, 1'b1, 1'b0};
    vecs[6] = '{-32768, 0, 1'b0, 1'b1};
    vecs[7] = '{32767, 10, 1'b1, 1'b0};
    vecs[8] = '{9, 9, 1'b0, 1'b0};
    vecs[9] = '{1, 1, 1'b0, 1'b0};

    #2;
    doReset();

    $display("[TB] idle with no command");
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("lo_before_3rd_edge", pwm_lo, 0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("lo_at_3rd_edge", pwm_lo, 1);
    countGates(2 * PERIOD, hi_c, lo_c, tick_c);
    checkOutput("idle_hi_count", hi_c, 0);
    checkOutput("idle_lo_count", lo_c, 2 * PERIOD);
    checkOutput("idle_tick_count", tick_c, 2);

    $display("[TB] duty 4 accepted at cnt 3");
    waitCnt(3);
    applyStimulus(1'b1, 1'b1, 4);
    checkOutput("ready_after_accept", cmd_ready, 0);
    waitCnt(0);
    checkOutput("duty4_applied", duty_active, 4);
    idle(PERIOD);
    countGates(PERIOD, hi_c, lo_c, tick_c);
    checkOutput("duty4_hi_count", hi_c, 2);
    checkOutput("duty4_lo_count", lo_c, 4);

    $display("[TB] saturation");
    sendCmd(-5);
    waitCnt(0);
    checkOutput("neg_duty", duty_active, 0);
    checkOutput("neg_sat_lo", sat_lo, 1);
    checkOutput("neg_sat_hi", sat_hi, 0);
    sendCmd(300);
    waitCnt(0);
    checkOutput("big_duty", duty_active, 10);
    checkOutput("big_sat_hi", sat_hi, 1);
    checkOutput("big_sat_lo", sat_lo, 0);
    idle(PERIOD);
    countGates(2 * PERIOD, hi_c, lo_c, tick_c);
    checkOutput("full_hi_count", hi_c, 2 * PERIOD);

    $display("[TB] back-to-back stall and wrap bypass");
    waitCnt(2);
    applyStimulus(1'b1, 1'b1, 3);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      applyStimulus(1'b1, 1'b1, 7);
      if (m_acc) break;
    end
    cmd_valid = 1'b0;
    checkOutput("stall_duty_first", duty_active, 3);
    checkOutput("stall_ready_low", cmd_ready, 0);
    waitCnt(0);
    checkOutput("stall_duty_second", duty_active, 7);
    waitCnt(9);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("bypass_duty", duty_active, 6);
    checkOutput("bypass_ready", cmd_ready, 1);

    $display("[TB] short pulse and enable drop");
    sendCmd(1);
    waitCnt(0);
    idle(PERIOD);
    countGates(PERIOD, hi_c, lo_c, tick_c);
    checkOutput("short_hi_count", hi_c, 0);
    checkOutput("short_lo_count", lo_c, PERIOD - 1 - DEADTIME);
    sendCmd(10);
    waitCnt(0);
    idle(PERIOD);
    checkOutput("hi_before_drop", pwm_hi, 1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("hi_after_drop", pwm_hi, 0);
    checkOutput("lo_after_drop", pwm_lo, 0);
    idle(PERIOD);

    $display("[TB] reset with pending command");
    waitCnt(2);
    applyStimulus(1'b1, 1'b1, 5);
    waitCnt(6);
    doReset();
    idle(2 * PERIOD);
    checkOutput("pending_discarded", duty_active, 0);

    $display("[TB] clamp table");
    foreach (vecs[i]) begin
      waitCnt($urandom_range(0, PERIOD - 2));
      sendCmd(vecs[i].cmd);
      waitCnt(0);
      checkOutput($sformatf("table%0d_duty", i), duty_active, vecs[i].exp_duty);
      checkOutput($sformatf("table%0d_sat_hi", i), sat_hi, vecs[i].exp_sat_hi);
      checkOutput($sformatf("table%0d_sat_lo", i), sat_lo, vecs[i].exp_sat_lo);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      e = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        r16 = 16'($urandom);
        c = int'(r16);
      end else begin
        c = int'($urandom_range(0, 30)) - 10;
      end
      applyStimulus(e, v, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
